// File: rtl/rainbow_pkg.sv
// Shared constants, RGB565 palette colours and FSM encoding for the rainbow pixel generator.
package rainbow_pkg;

  localparam int unsigned H_RES_DEF  = 160;
  localparam int unsigned V_RES_DEF  = 80;
  localparam int unsigned BAND_W_DEF = 20;
  localparam int unsigned NUM_BANDS  = 8;
  localparam int unsigned BAND_IDX_W = $clog2(NUM_BANDS);
  localparam int unsigned RGB_W      = 16;

  localparam logic [RGB_W-1:0] RGB_RED    = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_ORANGE = 16'hFC00;
  localparam logic [RGB_W-1:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [RGB_W-1:0] RGB_GREEN  = 16'h07E0;
  localparam logic [RGB_W-1:0] RGB_CYAN   = 16'h07FF;
  localparam logic [RGB_W-1:0] RGB_BLUE   = 16'h001F;
  localparam logic [RGB_W-1:0] RGB_VIOLET = 16'h801F;
  localparam logic [RGB_W-1:0] RGB_WHITE  = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/rainbow_palette.sv
// Combinational band index -> RGB565 colour lookup.
module rainbow_palette
  import rainbow_pkg::*;
(
  input  logic [BAND_IDX_W-1:0] idx,
  output logic [RGB_W-1:0]      rgb
);

  // Eight-entry rainbow table
  always_comb begin
    rgb = RGB_RED;
    case (idx)
      3'd0: rgb = RGB_RED;
      3'd1: rgb = RGB_ORANGE;
      3'd2: rgb = RGB_YELLOW;
      3'd3: rgb = RGB_GREEN;
      3'd4: rgb = RGB_CYAN;
      3'd5: rgb = RGB_BLUE;
      3'd6: rgb = RGB_VIOLET;
      3'd7: rgb = RGB_WHITE;
      default: rgb = RGB_RED;
    endcase
  end

endmodule

// File: rtl/rainbow_pixel_gen.sv
// Streams one frame of scrolling rainbow bands per request over a valid/ready pixel port.
module rainbow_pixel_gen
  import rainbow_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DEF,
  parameter int unsigned V_RES  = V_RES_DEF,
  parameter int unsigned BAND_W = BAND_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             FRAME_REQ,
  input  logic             PIX_READY,
  output logic             PIX_VALID,
  output logic [RGB_W-1:0] PIX_DATA,
  output logic             PIX_SOF,
  output logic             PIX_EOF,
  output logic             BUSY
);

  localparam int unsigned COL_W = (H_RES  > 1) ? $clog2(H_RES)  : 1;
  localparam int unsigned ROW_W = (V_RES  > 1) ? $clog2(V_RES)  : 1;
  localparam int unsigned SUB_W = (BAND_W > 1) ? $clog2(BAND_W) : 1;

  state_t                  state, state_nxt;
  logic [COL_W-1:0]        col, col_nxt;
  logic [ROW_W-1:0]        row, row_nxt;
  logic [BAND_IDX_W-1:0]   band, band_nxt;
  logic [SUB_W-1:0]        sub, sub_nxt;
  logic [BAND_IDX_W-1:0]   off_band, off_band_nxt;
  logic [SUB_W-1:0]        off_sub, off_sub_nxt;
  logic                    valid_nxt, sof_nxt, eof_nxt, busy_nxt;
  logic [RGB_W-1:0]        data_nxt, pal_rgb;
  logic                    load_pix, clear_pix;
  logic                    xfer, last_col, last_row, last_sub, last_off_sub;

  assign xfer         = PIX_VALID & PIX_READY;
  assign last_col     = (col == COL_W'(H_RES - 1));
  assign last_row     = (row == ROW_W'(V_RES - 1));
  assign last_sub     = (sub == SUB_W'(BAND_W - 1));
  assign last_off_sub = (off_sub == SUB_W'(BAND_W - 1));

  rainbow_palette u_palette (
    .idx (band_nxt),
    .rgb (pal_rgb)
  );

  // Next-state, pixel position and band tracking
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    band_nxt     = band;
    sub_nxt      = sub;
    off_band_nxt = off_band;
    off_sub_nxt  = off_sub;
    valid_nxt    = PIX_VALID;
    sof_nxt      = PIX_SOF;
    eof_nxt      = PIX_EOF;
    busy_nxt     = BUSY;
    load_pix     = 1'b0;
    clear_pix    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (FRAME_REQ) begin
          state_nxt = ST_STREAM;
          col_nxt   = '0;
          row_nxt   = '0;
          band_nxt  = off_band;
          sub_nxt   = off_sub;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          sof_nxt   = 1'b1;
          eof_nxt   = (H_RES == 1) && (V_RES == 1);
          load_pix  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          sof_nxt = 1'b0;
          if (last_col && last_row) begin
            // Frame done: drop the stream and scroll the pattern by one pixel
            state_nxt = ST_IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
            band_nxt  = '0;
            sub_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            eof_nxt   = 1'b0;
            clear_pix = 1'b1;
            if (last_off_sub) begin
              off_sub_nxt  = '0;
              off_band_nxt = off_band + BAND_IDX_W'(1);
            end else begin
              off_sub_nxt = off_sub + SUB_W'(1);
            end
          end else if (last_col) begin
            col_nxt  = '0;
            row_nxt  = row + ROW_W'(1);
            band_nxt = off_band;
            sub_nxt  = off_sub;
            load_pix = 1'b1;
            eof_nxt  = (col_nxt == COL_W'(H_RES - 1)) && (row_nxt == ROW_W'(V_RES - 1));
          end else begin
            col_nxt = col + COL_W'(1);
            if (last_sub) begin
              sub_nxt  = '0;
              band_nxt = band + BAND_IDX_W'(1);
            end else begin
              sub_nxt = sub + SUB_W'(1);
            end
            load_pix = 1'b1;
            eof_nxt  = (col_nxt == COL_W'(H_RES - 1)) && last_row;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pixel colour follows the band of the next pixel; held while stalled
  always_comb begin
    data_nxt = PIX_DATA;
    if (clear_pix) begin
      data_nxt = '0;
    end else if (load_pix) begin
      data_nxt = pal_rgb;
    end
  end

  // State, counters, scroll offset and registered pixel outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      band      <= '0;
      sub       <= '0;
      off_band  <= '0;
      off_sub   <= '0;
      PIX_VALID <= 1'b0;
      PIX_DATA  <= '0;
      PIX_SOF   <= 1'b0;
      PIX_EOF   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      band      <= band_nxt;
      sub       <= sub_nxt;
      off_band  <= off_band_nxt;
      off_sub   <= off_sub_nxt;
      PIX_VALID <= valid_nxt;
      PIX_DATA  <= data_nxt;
      PIX_SOF   <= sof_nxt;
      PIX_EOF   <= eof_nxt;
      BUSY      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rainbow_pixel_gen.sv
// Scoreboard bench: a default-size generator and a small one sharing clock and reset.
module tb_rainbow_pixel_gen;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] data;
  } exp_t;

  logic        CLK;
  logic        RSTN;
  logic        frame_req [2];
  logic        ready     [2];
  logic        valid     [2];
  logic [15:0] data      [2];
  logic        sof       [2];
  logic        eof       [2];
  logic        busy      [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int          n_chk;
  int          n_fail;
  int          cnt     [2];
  int          sofc    [2];
  int          eofc    [2];
  int          eof_idx [2];
  int          m_ob    [2];
  int          m_os    [2];
  bit          stalled [2];
  exp_t        held    [2];
  logic [15:0] cap [0:12799];
  exp_t        mon_e;
  bit          mon_have;

  rainbow_pixel_gen u_big (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .FRAME_REQ (frame_req[0]),
    .PIX_READY (ready[0]),
    .PIX_VALID (valid[0]),
    .PIX_DATA  (data[0]),
    .PIX_SOF   (sof[0]),
    .PIX_EOF   (eof[0]),
    .BUSY      (busy[0])
  );

  rainbow_pixel_gen #(.H_RES(8), .V_RES(3), .BAND_W(4)) u_sm (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .FRAME_REQ (frame_req[1]),
    .PIX_READY (ready[1]),
    .PIX_VALID (valid[1]),
    .PIX_DATA  (data[1]),
    .PIX_SOF   (sof[1]),
    .PIX_EOF   (eof[1]),
    .BUSY      (busy[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int hres(input int i); return (i == 0) ? 160 : 8; endfunction
  function automatic int vres(input int i); return (i == 0) ? 80 : 3; endfunction
  function automatic int bw(input int i);   return (i == 0) ? 20 : 4; endfunction

  function automatic logic [15:0] pal_ref(input int b);
    case (b)
      0: return 16'hF800;
      1: return 16'hFC00;
      2: return 16'hFFE0;
      3: return 16'h07E0;
      4: return 16'h07FF;
      5: return 16'h001F;
      6: return 16'h801F;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Pixel at (col,row) of a frame whose pattern is scrolled by ob bands plus os pixels
  function automatic exp_t model(input int i, input int col, input int row, input int ob, input int os);
    exp_t e;
    int   pos;
    pos    = ob * bw(i) + os + col;
    e.data = pal_ref((pos / bw(i)) % 8);
    e.sof  = (col == 0) && (row == 0);
    e.eof  = (col == hres(i) - 1) && (row == vres(i) - 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_frame(input int i);
    for (int r = 0; r < vres(i); r++) begin
      for (int c = 0; c < hres(i); c++) begin
        if (i == 0) sb0.push_back(model(i, c, r, m_ob[i], m_os[i]));
        else        sb1.push_back(model(i, c, r, m_ob[i], m_os[i]));
      end
    end
    m_os[i]++;
    if (m_os[i] == bw(i)) begin
      m_os[i] = 0;
      m_ob[i] = (m_ob[i] + 1) % 8;
    end
  endtask

  task automatic start_frame(input int i, input logic [15:0] first);
    cnt[i]     = 0;
    sofc[i]    = 0;
    eofc[i]    = 0;
    eof_idx[i] = -1;
    @(posedge CLK);
    #1 frame_req[i] = 1'b1;
    push_frame(i);
    @(posedge CLK);
    #1 frame_req[i] = 1'b0;
    check($sformatf("first_pixel%0d", i),
          {12'd0, valid[i], busy[i], sof[i], eof[i], data[i]},
          {12'd0, 1'b1, 1'b1, 1'b1, 1'b0, first});
  endtask

  task automatic wait_cnt(input int i, input int target, input int budget);
    int g = 0;
    while (cnt[i] < target && g < budget) begin
      @(posedge CLK);
      g++;
    end
    if (cnt[i] < target) check("wait_cnt_timeout", 32'(cnt[i]), 32'(target));
  endtask

  task automatic run_throttled(input int i, input int budget);
    int g = 0;
    while (eofc[i] == 0 && g < budget) begin
      @(posedge CLK);
      #1 ready[i] = ($urandom_range(0, 3) != 0);
      g++;
    end
    ready[i] = 1'b1;
    if (eofc[i] == 0) check("eof_timeout", 32'(eofc[i]), 32'd1);
  endtask

  task automatic end_checks(input int i, input int n);
    check($sformatf("idle_after_eof%0d", i), {30'd0, valid[i], busy[i]}, 32'd0);
    check($sformatf("xfer_count%0d", i), 32'(cnt[i]), 32'(n));
    check($sformatf("sof_count%0d", i), 32'(sofc[i]), 32'd1);
    check($sformatf("eof_count%0d", i), 32'(eofc[i]), 32'd1);
    check($sformatf("eof_index%0d", i), 32'(eof_idx[i]), 32'(n - 1));
    check($sformatf("sb_left%0d", i), (i == 0) ? 32'(sb0.size()) : 32'(sb1.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each transfer and checks stall stability
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RSTN) begin
        stalled[i] = 1'b0;
      end else begin
        if (stalled[i])
          check($sformatf("hold%0d", i), {13'd0, valid[i], sof[i], eof[i], data[i]}, {13'd0, 1'b1, held[i]});
        if (valid[i] && ready[i]) begin
          if (i == 0) begin
            mon_have = (sb0.size() != 0);
            if (mon_have) mon_e = sb0.pop_front();
          end else begin
            mon_have = (sb1.size() != 0);
            if (mon_have) mon_e = sb1.pop_front();
          end
          if (!mon_have)
            check($sformatf("sb_underflow%0d", i), 32'(cnt[i]), 32'hFFFF_FFFF);
          else
            check($sformatf("pix%0d_%0d", i, cnt[i]), {14'd0, sof[i], eof[i], data[i]}, {14'd0, mon_e});
          if (i == 0 && cnt[0] < 12800) cap[14'(cnt[0])] = data[0];
          if (sof[i]) sofc[i]++;
          if (eof[i]) begin
            eofc[i]++;
            eof_idx[i] = cnt[i];
          end
          cnt[i]++;
        end
        stalled[i] = valid[i] && !ready[i];
        held[i]    = {sof[i], eof[i], data[i]};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    logic [15:0] f;
    n_chk  = 0;
    n_fail = 0;
    RSTN   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frame_req[i] = 1'b0;
      ready[i]     = 1'b1;
      m_ob[i]      = 0;
      m_os[i]      = 0;
    end
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_state%0d", i), {12'd0, valid[i], busy[i], sof[i], eof[i], data[i]}, 32'd0);
    @(posedge CLK);
    #1 RSTN = 1'b1;

    // Frame 1: offset 0, stall at pixel 37, stray requests mid-frame and on EOF
    start_frame(0, 16'hF800);
    wait_cnt(0, 37, 100);
    #1 ready[0] = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1 check("stall_px37", {15'd0, valid[0], data[0]}, {15'd0, 1'b1, 16'hFC00});
    end
    ready[0] = 1'b1;
    wait_cnt(0, 500, 1000);
    #1 frame_req[0] = 1'b1;
    @(posedge CLK);
    #1 frame_req[0] = 1'b0;
    g = 0;
    while (!eof[0] && g < 20000) begin
      @(posedge CLK);
      #1 g++;
    end
    if (!eof[0]) check("eof_wait", {31'd0, eof[0]}, 32'd1);
    frame_req[0] = 1'b1;
    @(posedge CLK);
    #1 frame_req[0] = 1'b0;
    end_checks(0, 12800);
    repeat (3) @(posedge CLK);
    #1 check("req_not_queued", {30'd0, valid[0], busy[0]}, 32'd0);
    check("f1_px0",     {16'd0, cap[0]},     32'h0000_F800);
    check("f1_px20",    {16'd0, cap[20]},    32'h0000_FC00);
    check("f1_px159",   {16'd0, cap[159]},   32'h0000_FFFF);
    check("f1_px160",   {16'd0, cap[160]},   32'h0000_F800);
    check("f1_px12799", {16'd0, cap[12799]}, 32'h0000_FFFF);

    // Frame 2: offset one pixel, random READY throttling
    start_frame(0, 16'hF800);
    run_throttled(0, 40000);
    end_checks(0, 12800);
    check("f2_px0",   {16'd0, cap[0]},   32'h0000_F800);
    check("f2_px19",  {16'd0, cap[19]},  32'h0000_FC00);
    check("f2_px159", {16'd0, cap[159]}, 32'h0000_F800);

    // Frame 3: asynchronous reset mid-cycle at pixel 500
    start_frame(0, 16'hF800);
    wait_cnt(0, 500, 1000);
    #3 RSTN = 1'b0;
    #1 check("async_reset", {12'd0, valid[0], busy[0], sof[0], eof[0], data[0]}, 32'd0);
    sb0.delete();
    sb1.delete();
    for (int i = 0; i < 2; i++) begin
      m_ob[i] = 0;
      m_os[i] = 0;
    end
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    start_frame(0, 16'hF800);
    wait_cnt(0, 200, 400);
    #3 RSTN = 1'b0;
    #1 sb0.delete();
    m_ob[0] = 0;
    m_os[0] = 0;
    @(posedge CLK);
    #1 RSTN = 1'b1;

    // Small geometry: throttled frames across a full wrap of the scroll offset
    for (int k = 0; k < 34; k++) begin
      f = model(1, 0, 0, m_ob[1], m_os[1]).data;
      if (k == 4)  f = 16'hFC00;
      if (k == 31) f = 16'hFFFF;
      if (k == 32) f = 16'hF800;
      start_frame(1, f);
      run_throttled(1, 200);
      end_checks(1, 24);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
